// File: rtl/byte_window_fifo.sv
// Byte-granular circular FIFO: IN_BYTES-wide words in, WIN_BYTES-wide sliding windows out.
// Latency: a pushed word is visible on out_data/level one cycle after acceptance.
// Backpressure: in_ready drops when a full word no longer fits; out_valid needs WIN_BYTES stored.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 row complete: empty the FIFO (no transfer that cycle)
//   stride                bytes consumed per pop (0 -> 1, >WIN_BYTES -> WIN_BYTES)
//   in_data/valid/ready   input word, byte 0 in bits [7:0] is the oldest byte
//   out_data/valid/ready  window, byte 0 in bits [7:0] is the byte at the read pointer
//   level                 bytes currently stored
module byte_window_fifo #(
  parameter int IN_BYTES    = 8,
  parameter int WIN_BYTES   = 3,
  parameter int DEPTH_BYTES = 15,
  parameter int SW          = 2,
  localparam int LW         = $clog2(DEPTH_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [SW-1:0]          stride,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8*WIN_BYTES-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LW-1:0]          level
);

  localparam int PW = $clog2(DEPTH_BYTES);

  logic [7:0]    r_mem [DEPTH_BYTES];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_s_eff;
  logic [LW-1:0] w_level_nxt;

  // Explicit modulo add: the depth need not be a power of two, so binary
  // overflow of the pointer cannot be used for wrapping. inc < 2*DEPTH_BYTES.
  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] ptr, input int inc);
    int sum;
    sum = int'(32'(ptr)) + inc;
    if (sum >= DEPTH_BYTES) sum = sum - DEPTH_BYTES;
    return sum[PW-1:0];
  endfunction

  // Registered level only: a pop in the same cycle does not open room for a push.
  assign in_ready  = !flush && (int'(32'(r_level)) + IN_BYTES <= DEPTH_BYTES);
  assign out_valid = !flush && (int'(32'(r_level)) >= WIN_BYTES);
  assign level     = r_level;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    w_s_eff = LW'(1);
    if (stride == '0)
      w_s_eff = LW'(1);
    else if (int'(32'(stride)) > WIN_BYTES)
      w_s_eff = LW'(WIN_BYTES);
    else
      w_s_eff = LW'(stride);
  end

  // Push is only granted when the word fits, so the sum stays within LW bits.
  assign w_level_nxt = r_level + (w_push ? LW'(IN_BYTES) : '0) - (w_pop ? w_s_eff : '0);

  // Window is read straight from storage; a window across the wrap point is contiguous.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      out_data[8*i +: 8] = r_mem[f_wrap(r_rd_ptr, i)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as is; only the bookkeeping is cleared.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        for (int i = 0; i < IN_BYTES; i++) begin
          r_mem[f_wrap(r_wr_ptr, i)] <= in_data[8*i +: 8];
        end
        r_wr_ptr <= f_wrap(r_wr_ptr, IN_BYTES);
      end
      if (w_pop) begin
        r_rd_ptr <= f_wrap(r_rd_ptr, int'(32'(w_s_eff)));
      end
      r_level <= w_level_nxt;
    end
  end

endmodule
